// File: rtl/dup_pair_gen_if.sv
// dup_pair_gen_if -- handshake/bus bundle for the redundant-pair generator.
//   start, ke_width, ke_height, hdist, vdist : job request and geometry
//   busy, done, empty, overflow              : job status
//   pair_valid, pair_ready, idx1, idx2       : pair stream (valid/ready)
// master = job issuer / pair consumer, slave = dup_pair_gen.
interface dup_pair_gen_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  start;
  logic [WORD_WIDTH-1:0] ke_width;
  logic [WORD_WIDTH-1:0] ke_height;
  logic [WORD_WIDTH-1:0] hdist;
  logic [WORD_WIDTH-1:0] vdist;
  logic                  busy;
  logic                  pair_valid;
  logic                  pair_ready;
  logic [WORD_WIDTH-1:0] idx1;
  logic [WORD_WIDTH-1:0] idx2;
  logic                  done;
  logic                  empty;
  logic                  overflow;

  modport master (
    output start, ke_width, ke_height, hdist, vdist, pair_ready,
    input  busy, pair_valid, idx1, idx2, done, empty, overflow
  );

  modport slave (
    input  start, ke_width, ke_height, hdist, vdist, pair_ready,
    output busy, pair_valid, idx1, idx2, done, empty, overflow
  );
endinterface

// File: rtl/dup_pair_gen.sv
// dup_pair_gen -- enumerates every lowered-index pair (idx1, idx2) of a
// FW x FH kernel whose elements are (dh, dv) apart:
//   idx1 = r*FW + c, idx2 = (r+dv)*FW + (c+dh)
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : dup_pair_gen_if.slave (job request, status, pair stream)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; geometry latched and checked on start
// S_PREP | building offset = dv*FW + dh by repeated addition
// S_EMIT | presenting pairs, advancing on each accepted transfer
// S_DONE | one-cycle done pulse, then back to idle
module dup_pair_gen #(
  parameter int WORD_WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  dup_pair_gen_if.slave  bus
);
  localparam int W = WORD_WIDTH;
  localparam logic [W-1:0] ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W:0]   ONE_X = {{W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_EMIT,
    S_DONE
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_fw;
  logic [W-1:0] r_fh;
  logic [W-1:0] r_dh;
  logic [W-1:0] r_dv;
  logic [W-1:0] r_prep_cnt;
  logic [W-1:0] r_r;
  logic [W-1:0] r_c;
  logic [W:0]   r_offset;
  logic [W-1:0] r_idx1;
  logic [W-1:0] r_idx2;
  logic         r_busy;
  logic         r_valid;
  logic         r_done;
  logic         r_empty;
  logic         r_ovf;

  logic         w_bad_geom;
  logic [W-1:0] w_c_last;
  logic [W-1:0] w_r_last;
  logic         w_row_end;
  logic         w_last_pair;
  logic [W:0]   w_prep_sum;
  logic [W:0]   w_idx1_next;
  logic [W:0]   w_idx2_next;

  assign w_bad_geom = (bus.ke_width == '0) || (bus.ke_height == '0) ||
                      (bus.hdist >= bus.ke_width) || (bus.vdist >= bus.ke_height);

  // Only meaningful once the geometry has passed the check at start.
  assign w_c_last    = r_fw - r_dh - ONE;
  assign w_r_last    = r_fh - r_dv - ONE;
  assign w_row_end   = (r_c == w_c_last);
  assign w_last_pair = w_row_end && (r_r == w_r_last);

  // Offset stays below 2^W while PREP runs, so one extra bit never wraps.
  assign w_prep_sum = r_offset + {1'b0, (r_prep_cnt != '0) ? r_fw : r_dh};

  // The next pair is looked ahead so pair_valid can be a plain register
  // that never rises on a pair whose idx2 is out of range. The current
  // idx2 fits in W bits, which bounds both sums below 2^(W+1).
  assign w_idx1_next = w_row_end ? ({1'b0, r_idx1} + {1'b0, r_dh} + ONE_X)
                                 : ({1'b0, r_idx1} + ONE_X);
  assign w_idx2_next = w_idx1_next + r_offset;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_fw       <= '0;
      r_fh       <= '0;
      r_dh       <= '0;
      r_dv       <= '0;
      r_prep_cnt <= '0;
      r_r        <= '0;
      r_c        <= '0;
      r_offset   <= '0;
      r_idx1     <= '0;
      r_idx2     <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_empty    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_fw       <= bus.ke_width;
            r_fh       <= bus.ke_height;
            r_dh       <= bus.hdist;
            r_dv       <= bus.vdist;
            r_prep_cnt <= bus.vdist;
            r_offset   <= '0;
            r_r        <= '0;
            r_c        <= '0;
            r_idx1     <= '0;
            r_idx2     <= '0;
            r_ovf      <= 1'b0;
            r_empty    <= w_bad_geom;
            r_busy     <= 1'b1;
            if (w_bad_geom) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_PREP;
            end
          end
        end

        S_PREP: begin
          if (w_prep_sum[W]) begin
            r_ovf   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_offset <= w_prep_sum;
            if (r_prep_cnt != '0) begin
              r_prep_cnt <= r_prep_cnt - ONE;
            end else begin
              // idx1 is 0 here, so the first idx2 is the offset itself.
              r_idx2  <= w_prep_sum[W-1:0];
              r_valid <= 1'b1;
              r_state <= S_EMIT;
            end
          end
        end

        S_EMIT: begin
          if (bus.pair_ready) begin
            if (w_last_pair) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (w_idx2_next[W]) begin
              r_valid <= 1'b0;
              r_ovf   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx1 <= w_idx1_next[W-1:0];
              r_idx2 <= w_idx2_next[W-1:0];
              if (w_row_end) begin
                r_c <= '0;
                r_r <= r_r + ONE;
              end else begin
                r_c <= r_c + ONE;
              end
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.pair_valid = r_valid;
  assign bus.idx1       = r_idx1;
  assign bus.idx2       = r_idx2;
  assign bus.done       = r_done;
  assign bus.empty      = r_empty;
  assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_dup_pair_gen.sv
module tb_dup_pair_gen;
  localparam int W    = 8;
  localparam int IMAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dup_pair_gen_if #(.WORD_WIDTH(W)) bus_if ();
  dup_pair_gen #(.WORD_WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus_if));

  typedef struct {int i1; int i2;} pair_t;
  typedef struct {bit empty; bit ovf;} end_t;

  pair_t exp_q[$];
  end_t  end_q[$];
  int n_pass = 0;
  int n_total = 0;
  int n_done = 0;
  int rdy_mode = 0;
  int stall_cnt = 0;
  int hold_1 = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fail(input string name, input int act);
    n_total++;
    $display("FAIL %s: got %0d, expected none", name, act);
  endtask

  // Reference: enumerate pairs straight from the kernel geometry.
  task automatic model(input int fw, input int fh, input int dh, input int dv, output int np);
    end_t e;
    pair_t p;
    bit stop;
    stop = 0;
    np = 0;
    e.empty = (fw == 0) || (fh == 0) || (dh >= fw) || (dv >= fh);
    e.ovf = 0;
    if (!e.empty) begin
      for (int r = 0; r <= fh - 1 - dv; r++)
        for (int c = 0; c <= fw - 1 - dh; c++)
          if (!stop) begin
            p.i1 = r * fw + c;
            p.i2 = (r + dv) * fw + c + dh;
            if (p.i2 > IMAX) begin
              e.ovf = 1;
              stop = 1;
            end else begin
              exp_q.push_back(p);
              np++;
            end
          end
    end
    end_q.push_back(e);
  endtask

  // Ready driver: always / random / stall 3 cycles on the pair with idx1==1.
  initial begin
    bus_if.pair_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus_if.pair_ready = 1'b1;
        1: bus_if.pair_ready = 1'($urandom_range(0, 1));
        default: begin
          if (bus_if.pair_valid && bus_if.idx1 == 1 && stall_cnt < 3) begin
            bus_if.pair_ready = 1'b0;
            stall_cnt++;
          end else begin
            bus_if.pair_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    pair_t p;
    end_t e;
    int pres;
    bit pv, pr, pd;
    int pi1, pi2;
    pres = 0; pv = 0; pr = 0; pd = 0; pi1 = 0; pi2 = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pres = 0; pv = 0; pd = 0;
      end else begin
        if (pv && !pr) begin
          chk("hold_valid", int'(bus_if.pair_valid), 1);
          chk("hold_idx1", int'(bus_if.idx1), pi1);
          chk("hold_idx2", int'(bus_if.idx2), pi2);
        end
        if (bus_if.pair_valid) begin
          pres++;
          if (bus_if.pair_ready) begin
            if (exp_q.size() == 0) begin
              fail("unexpected_pair_idx1", int'(bus_if.idx1));
            end else begin
              p = exp_q.pop_front();
              chk("pair_idx1", int'(bus_if.idx1), p.i1);
              chk("pair_idx2", int'(bus_if.idx2), p.i2);
            end
            if (bus_if.idx1 == 1) hold_1 = pres;
            pres = 0;
          end
        end
        if (bus_if.done) begin
          chk("done_width", int'(pd), 0);
          if (end_q.size() == 0) begin
            fail("unexpected_done", 1);
          end else begin
            e = end_q.pop_front();
            chk("end_empty", int'(bus_if.empty), int'(e.empty));
            chk("end_overflow", int'(bus_if.overflow), int'(e.ovf));
            chk("pairs_left", exp_q.size(), 0);
          end
          n_done++;
        end
        pv = bus_if.pair_valid;
        pr = bus_if.pair_ready;
        pi1 = int'(bus_if.idx1);
        pi2 = int'(bus_if.idx2);
        pd = bus_if.done;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, int'(bus_if.busy), 0);
    chk({tag, "_valid"}, int'(bus_if.pair_valid), 0);
    chk({tag, "_done"}, int'(bus_if.done), 0);
    chk({tag, "_empty"}, int'(bus_if.empty), 0);
    chk({tag, "_overflow"}, int'(bus_if.overflow), 0);
    chk({tag, "_idx1"}, int'(bus_if.idx1), 0);
    chk({tag, "_idx2"}, int'(bus_if.idx2), 0);
  endtask

  // Issues start; returns just after the edge that samples it.
  task automatic launch(input int fw, input int fh, input int dh, input int dv, output int np);
    model(fw, fh, dh, dv, np);
    @(posedge clk);
    #1;
    bus_if.ke_width  = W'(fw);
    bus_if.ke_height = W'(fh);
    bus_if.hdist     = W'(dh);
    bus_if.vdist     = W'(dv);
    bus_if.start     = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start     = 1'b0;
    bus_if.ke_width  = W'($urandom);
    bus_if.ke_height = W'($urandom);
    bus_if.hdist     = W'($urandom);
    bus_if.vdist     = W'($urandom);
  endtask

  task automatic run_job(input int fw, input int fh, input int dh, input int dv, input bit pulse);
    int d0, np, cyc, lat;
    bit seen, is_empty;
    d0 = n_done;
    is_empty = (fw == 0) || (fh == 0) || (dh >= fw) || (dv >= fh);
    launch(fw, fh, dh, dv, np);
    if (pulse) begin
      bus_if.ke_width = 8'd2; bus_if.ke_height = 8'd2;
      bus_if.hdist = 8'd0; bus_if.vdist = 8'd0;
      bus_if.start = 1'b1;
    end
    if (is_empty) begin
      chk("empty_done_at_once", int'(bus_if.done), 1);
      chk("empty_flag", int'(bus_if.empty), 1);
    end
    cyc = 0; lat = 0; seen = 0;
    while (n_done == d0 && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
      bus_if.start = 1'b0;
      if (!seen && bus_if.pair_valid) begin
        seen = 1;
        lat = cyc;
      end
    end
    bus_if.start = 1'b0;
    if (n_done == d0) fail("done_timeout", cyc);
    if (np > 0) chk("first_valid_latency", lat, dv + 1);
    if (is_empty) chk("empty_never_valid", int'(seen), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", int'(bus_if.busy), 0);
    chk("idle_end_q", end_q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int np, cyc, fw, fh, dh, dv;
    bus_if.start = 1'b0;
    bus_if.ke_width = '0; bus_if.ke_height = '0;
    bus_if.hdist = '0; bus_if.vdist = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_reset_busy", int'(bus_if.busy), 0);

    rdy_mode = 0;
    run_job(3, 3, 1, 0, 0);
    run_job(3, 3, 1, 1, 0);

    rdy_mode = 2; stall_cnt = 0; hold_1 = 0;
    run_job(3, 3, 1, 1, 0);
    chk("stall_hold_cycles", hold_1, 4);

    rdy_mode = 0;
    run_job(3, 3, 3, 0, 1);
    run_job(3, 3, 1, 1, 1);
    run_job(16, 17, 0, 1, 0);
    run_job(200, 5, 10, 2, 0);

    // Reset mid-EMIT, then a fresh job.
    launch(3, 3, 1, 1, np);
    cyc = 0;
    while (!bus_if.pair_valid && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rst_test_valid_seen", int'(bus_if.pair_valid), 1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    end_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("after_reset_busy", int'(bus_if.busy), 0);
    chk("after_reset_valid", int'(bus_if.pair_valid), 0);
    run_job(3, 3, 1, 0, 0);

    rdy_mode = 1;
    for (int j = 0; j < 40; j++) begin
      if (j % 5 == 4) begin
        fw = $urandom_range(20, 60);
        fh = $urandom_range(4, 12);
        dh = $urandom_range(0, fw);
        dv = $urandom_range(0, fh);
      end else begin
        fw = $urandom_range(0, 9);
        fh = $urandom_range(0, 9);
        dh = $urandom_range(0, 9);
        dv = $urandom_range(0, 9);
      end
      run_job(fw, fh, dh, dv, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
